// File: rtl/ascon_tag_verify_if.sv
// Plaintext read port of ascon_tag_verify.
//   rd_valid : a released plaintext word is on rd_data
//   rd_ready : the consumer accepts the word when rd_valid & rd_ready
//   rd_data  : 32-bit plaintext word, MSB-first
//   rd_last  : the current word is the final word of the plaintext
// The master modport is the verifier side and the slave modport is the consumer side.
interface ascon_tag_verify_if;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_data;
    logic        rd_last;

    modport master (output rd_valid, output rd_data, output rd_last, input rd_ready);
    modport slave  (input rd_valid, input rd_data, input rd_last, output rd_ready);
endinterface

// File: rtl/ascon_tag_verify.sv
// ascon_tag_verify: this module gates the plaintext from an Ascon decryption core
// behind a constant-time tag comparison. Plaintext leaves the module only after the
// computed tag matches the received tag. On a mismatch the plaintext is wiped.
//
// Ports:
//   clk, rst    : clock and asynchronous active-low reset
//   start/abort : one-cycle requests to begin or to cancel an operation
//   exp_tag     : received tag, captured when start is accepted
//   dec_start   : one-cycle start pulse to the decryption core
//   dec_ready   : level done flag from the core; pt_in and tag_in are valid while it is high
//   rd          : plaintext read port (ascon_tag_verify_if.master)
//   auth_ok     : the tags matched and the plaintext is released
//   auth_fail   : the tags differed and the plaintext is discarded
//   busy        : an operation is in progress
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for start
// LAUNCH   | one cycle; dec_start is high
// WAIT_DEC | waiting for dec_ready; then captures plaintext and tag
// COMPARE  | four cycles; ORs the XOR of each 32-bit tag word into diff
// RELEASE  | presents the plaintext words on rd, one per handshake
// DONE     | authenticated; auth_ok holds
// FAIL     | rejected; auth_fail holds and the buffers are zero
module ascon_tag_verify #(
    parameter int y  = 40,
    parameter int NW = (y + 31) / 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    input  logic [127:0]                 exp_tag,
    output logic                         dec_start,
    input  logic                         dec_ready,
    input  logic [((y > 0) ? y : 1)-1:0] pt_in,
    input  logic [127:0]                 tag_in,
    ascon_tag_verify_if.master           rd,
    output logic                         auth_ok,
    output logic                         auth_fail,
    output logic                         busy
);
    // A y=0 build keeps a one-bit buffer that always holds zero.
    localparam int PW   = (y > 0) ? y : 1;
    localparam int NWP  = (NW > 0) ? NW : 1;
    localparam int PADW = NWP * 32;
    localparam int IW   = (NWP > 1) ? $clog2(NWP) : 1;

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_DEC, COMPARE, RELEASE, DONE, FAIL} state_t;

    state_t          state_q, state_d;
    logic [1:0]      rst_sync;
    logic            rst_int;
    logic [127:0]    exp_q, tag_q;
    logic [PW-1:0]   pt_q;
    logic [31:0]     diff_q, diff_next, tag_w, exp_w, pt_word;
    logic [1:0]      cnt_q;
    logic [IW-1:0]   idx_q;
    logic [PADW-1:0] pt_ext;
    logic            last_word;

    // Reset asserts at once and deasserts after two clock edges.
    // No state changes before the second rising edge after rst is released.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync <= 2'b00;
        else      rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int = rst_sync[1];

    // Word cnt_q of both tags, taken from bit 127 downward.
    always_comb begin
        tag_w = '0;
        exp_w = '0;
        for (int k = 0; k < 4; k++) begin
            if (cnt_q == 2'(k)) begin
                tag_w = tag_q[127-32*k -: 32];
                exp_w = exp_q[127-32*k -: 32];
            end
        end
    end
    assign diff_next = diff_q | (tag_w ^ exp_w);

    // The plaintext is left-aligned in a whole number of words, so the partial
    // last word is padded with zeros at the bottom.
    assign pt_ext = PADW'(pt_q) << (PADW - PW);

    always_comb begin
        pt_word = '0;
        for (int k = 0; k < NWP; k++) begin
            if (idx_q == IW'(k)) pt_word = pt_ext[PADW-1-32*k -: 32];
        end
    end
    assign last_word = (idx_q == IW'(NWP - 1));

    always_ff @(posedge clk or negedge rst_int) begin
        if (!rst_int) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        dec_start   = 1'b0;
        rd.rd_valid = 1'b0;
        rd.rd_data  = '0;
        rd.rd_last  = 1'b0;
        busy        = 1'b1;
        case (state_q)
            IDLE:     begin
                busy = 1'b0;
                if (start) state_d = LAUNCH;
            end
            LAUNCH:   begin
                dec_start = 1'b1;
                state_d   = WAIT_DEC;
            end
            WAIT_DEC: if (dec_ready) state_d = COMPARE;
            COMPARE:  begin
                if (cnt_q == 2'd3) begin
                    if (diff_next == '0) state_d = (y == 0) ? DONE : RELEASE;
                    else                 state_d = FAIL;
                end
            end
            RELEASE:  begin
                rd.rd_valid = 1'b1;
                rd.rd_data  = pt_word;
                rd.rd_last  = last_word;
                if (rd.rd_ready && last_word) state_d = DONE;
            end
            DONE, FAIL: begin
                busy = 1'b0;
                if (start) state_d = LAUNCH;
            end
            default:  state_d = IDLE;
        endcase
        // abort overrides every other event in the same cycle.
        if (abort) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_int) begin
        if (!rst_int) begin
            exp_q     <= '0;
            tag_q     <= '0;
            pt_q      <= '0;
            diff_q    <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            auth_ok   <= 1'b0;
            auth_fail <= 1'b0;
        end else if (abort) begin
            exp_q     <= '0;
            tag_q     <= '0;
            pt_q      <= '0;
            diff_q    <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            auth_ok   <= 1'b0;
            auth_fail <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE, FAIL: begin
                    if (start) begin
                        exp_q     <= exp_tag;
                        auth_ok   <= 1'b0;
                        auth_fail <= 1'b0;
                    end
                end
                WAIT_DEC: begin
                    if (dec_ready) begin
                        pt_q   <= pt_in;
                        tag_q  <= tag_in;
                        diff_q <= '0;
                        cnt_q  <= '0;
                        idx_q  <= '0;
                    end
                end
                COMPARE: begin
                    diff_q <= diff_next;
                    cnt_q  <= cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        if (diff_next == '0) begin
                            auth_ok <= 1'b1;
                        end else begin
                            auth_fail <= 1'b1;
                            pt_q      <= '0;
                            tag_q     <= '0;
                        end
                    end
                end
                RELEASE: begin
                    if (rd.rd_ready) begin
                        if (last_word) pt_q  <= '0;
                        else           idx_q <= idx_q + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ascon_tag_verify.sv
// Testbench for ascon_tag_verify. It drives two instances: one with y=40 and one
// with y=0. Each test uses directed vectors and hand-computed expected values.
module tb_ascon_tag_verify;
    localparam logic [127:0] TAG_A5  = {16{8'hA5}};
    localparam logic [127:0] TAG_BAD = {16{8'hA5}} ^ 128'h1;
    localparam logic [39:0]  PT      = 40'h0123456789;
    localparam logic [127:0] TAG_Y0  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0, abort = 1'b0, dec_ready = 1'b0;
    logic [127:0] exp_tag = '0, tag_in = '0;
    logic [39:0]  pt_in = '0;
    logic         dec_start, auth_ok, auth_fail, busy;

    logic         start1 = 1'b0, abort1 = 1'b0, dec_ready1 = 1'b0;
    logic [127:0] exp_tag1 = '0, tag_in1 = '0;
    logic [0:0]   pt_in1 = '0;
    logic         dec_start1, auth_ok1, auth_fail1, busy1;

    int checks = 0;
    int failures = 0;
    int ds_cnt = 0, rv_cnt = 0, hs_cnt = 0, ds1_cnt = 0, rv1_cnt = 0;

    always #5 clk = ~clk;

    ascon_tag_verify_if rd0();
    ascon_tag_verify_if rd1();

    ascon_tag_verify #(.y(40)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .exp_tag(exp_tag),
        .dec_start(dec_start), .dec_ready(dec_ready), .pt_in(pt_in), .tag_in(tag_in),
        .rd(rd0), .auth_ok(auth_ok), .auth_fail(auth_fail), .busy(busy)
    );

    ascon_tag_verify #(.y(0)) dut_y0 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1), .exp_tag(exp_tag1),
        .dec_start(dec_start1), .dec_ready(dec_ready1), .pt_in(pt_in1), .tag_in(tag_in1),
        .rd(rd1), .auth_ok(auth_ok1), .auth_fail(auth_fail1), .busy(busy1)
    );

    // Inputs change 1 time unit after posedge, so the values seen at negedge are
    // the values that the next rising edge samples.
    always @(negedge clk) begin
        if (dec_start)                      ds_cnt++;
        if (rd0.rd_valid)                   rv_cnt++;
        if (rd0.rd_valid && rd0.rd_ready)   hs_cnt++;
        if (dec_start1)                     ds1_cnt++;
        if (rd1.rd_valid)                   rv1_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one operation on the y=40 instance up to the first cycle after COMPARE.
    task automatic do_op(input logic [127:0] tv, input string nm);
        dec_ready = 1'b0;
        exp_tag   = TAG_A5;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        checks++;
        if (dec_start !== 1'b1 || auth_ok !== 1'b0 || auth_fail !== 1'b0) begin
            failures++;
            $display("FAIL %s_launch dec_start=%0b ok=%0b fail=%0b expected 1 0 0", nm, dec_start, auth_ok, auth_fail);
        end
        tick();
        checks++;
        if (dec_start !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL %s_wait dec_start=%0b busy=%0b expected 0 1", nm, dec_start, busy);
        end
        pt_in     = PT;
        tag_in    = tv;
        dec_ready = 1'b1;
        tick();
        dec_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (auth_ok !== 1'b0 || auth_fail !== 1'b0 || busy !== 1'b1 || rd0.rd_valid !== 1'b0) begin
                failures++;
                $display("FAIL %s_compare%0d ok=%0b fail=%0b busy=%0b rd_valid=%0b expected 0 0 1 0",
                         nm, i, auth_ok, auth_fail, busy, rd0.rd_valid);
            end
            tick();
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if ({dec_start, rd0.rd_valid, rd0.rd_data, rd0.rd_last, auth_ok, auth_fail, busy} !== 38'h0) begin
            failures++;
            $display("FAIL reset_outputs got ds=%0b rv=%0b data=%h last=%0b ok=%0b fail=%0b busy=%0b expected all 0",
                     dec_start, rd0.rd_valid, rd0.rd_data, rd0.rd_last, auth_ok, auth_fail, busy);
        end
        checks++;
        if ({dec_start1, rd1.rd_valid, auth_ok1, auth_fail1, busy1} !== 5'h0) begin
            failures++;
            $display("FAIL reset_outputs_y0 got %b expected 00000", {dec_start1, rd1.rd_valid, auth_ok1, auth_fail1, busy1});
        end
        // A start on the first edge after release must be ignored.
        rst   = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || dec_start !== 1'b0) begin
            failures++;
            $display("FAIL reset_sync busy=%0b dec_start=%0b expected 0 0", busy, dec_start);
        end
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (busy !== 1'b0 || ds_cnt !== 0) begin
            failures++;
            $display("FAIL reset_sync_idle busy=%0b dec_starts=%0d expected 0 0", busy, ds_cnt);
        end
    endtask

    task automatic test_match();
        int b;
        b = ds_cnt;
        rd0.rd_ready = 1'b1;
        do_op(TAG_A5, "match");
        checks++;
        if (auth_ok !== 1'b1 || auth_fail !== 1'b0 || rd0.rd_valid !== 1'b1 ||
            rd0.rd_data !== 32'h01234567 || rd0.rd_last !== 1'b0) begin
            failures++;
            $display("FAIL match_word0 ok=%0b fail=%0b rv=%0b data=%h last=%0b expected 1 0 1 01234567 0",
                     auth_ok, auth_fail, rd0.rd_valid, rd0.rd_data, rd0.rd_last);
        end
        tick();
        checks++;
        if (rd0.rd_valid !== 1'b1 || rd0.rd_data !== 32'h89000000 || rd0.rd_last !== 1'b1) begin
            failures++;
            $display("FAIL match_word1 rv=%0b data=%h last=%0b expected 1 89000000 1",
                     rd0.rd_valid, rd0.rd_data, rd0.rd_last);
        end
        tick();
        checks++;
        if (rd0.rd_valid !== 1'b0 || rd0.rd_data !== 32'h0 || rd0.rd_last !== 1'b0 || busy !== 1'b0 || auth_ok !== 1'b1) begin
            failures++;
            $display("FAIL match_done rv=%0b data=%h last=%0b busy=%0b ok=%0b expected 0 0 0 0 1",
                     rd0.rd_valid, rd0.rd_data, rd0.rd_last, busy, auth_ok);
        end
        checks++;
        if (ds_cnt - b !== 1) begin
            failures++;
            $display("FAIL match_dec_start_pulses got %0d expected 1", ds_cnt - b);
        end
    endtask

    task automatic test_mismatch();
        int b;
        b = rv_cnt;
        do_op(TAG_BAD, "mismatch");
        checks++;
        if (auth_fail !== 1'b1 || auth_ok !== 1'b0 || busy !== 1'b0 || rd0.rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL mismatch_result fail=%0b ok=%0b busy=%0b rv=%0b expected 1 0 0 0",
                     auth_fail, auth_ok, busy, rd0.rd_valid);
        end
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (auth_fail !== 1'b1 || rd0.rd_data !== 32'h0 || rv_cnt - b !== 0) begin
            failures++;
            $display("FAIL mismatch_hold fail=%0b data=%h valid_cycles=%0d expected 1 0 0",
                     auth_fail, rd0.rd_data, rv_cnt - b);
        end
    endtask

    task automatic test_stall();
        int b;
        rd0.rd_ready = 1'b0;
        do_op(TAG_A5, "stall");
        b = hs_cnt;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rd0.rd_valid !== 1'b1 || rd0.rd_data !== 32'h01234567 || rd0.rd_last !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold%0d rv=%0b data=%h last=%0b expected 1 01234567 0",
                         i, rd0.rd_valid, rd0.rd_data, rd0.rd_last);
            end
            tick();
        end
        rd0.rd_ready = 1'b1;
        #1;
        checks++;
        if (rd0.rd_data !== 32'h01234567) begin
            failures++;
            $display("FAIL stall_release data=%h expected 01234567", rd0.rd_data);
        end
        tick();
        checks++;
        if (rd0.rd_data !== 32'h89000000 || rd0.rd_last !== 1'b1) begin
            failures++;
            $display("FAIL stall_word1 data=%h last=%0b expected 89000000 1", rd0.rd_data, rd0.rd_last);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || auth_ok !== 1'b1 || hs_cnt - b !== 2) begin
            failures++;
            $display("FAIL stall_done busy=%0b ok=%0b handshakes=%0d expected 0 1 2", busy, auth_ok, hs_cnt - b);
        end
    endtask

    task automatic test_abort_compare();
        int b;
        exp_tag = TAG_A5;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        tick();
        pt_in     = PT;
        tag_in    = TAG_A5;
        dec_ready = 1'b1;
        tick();
        dec_ready = 1'b0;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if ({busy, auth_ok, auth_fail, rd0.rd_valid, dec_start, rd0.rd_data} !== 37'h0) begin
            failures++;
            $display("FAIL abort_compare busy=%0b ok=%0b fail=%0b rv=%0b ds=%0b data=%h expected all 0",
                     busy, auth_ok, auth_fail, rd0.rd_valid, dec_start, rd0.rd_data);
        end
        b = rv_cnt;
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (auth_ok !== 1'b0 || busy !== 1'b0 || rv_cnt - b !== 0) begin
            failures++;
            $display("FAIL abort_compare_idle ok=%0b busy=%0b valid_cycles=%0d expected 0 0 0", auth_ok, busy, rv_cnt - b);
        end
    endtask

    task automatic test_abort_release();
        int b;
        rd0.rd_ready = 1'b1;
        do_op(TAG_A5, "abort_rel");
        tick();
        checks++;
        if (rd0.rd_data !== 32'h89000000) begin
            failures++;
            $display("FAIL abort_rel_word1 data=%h expected 89000000", rd0.rd_data);
        end
        // The final handshake is offered in the same cycle as abort, and abort wins.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if ({busy, auth_ok, auth_fail, rd0.rd_valid, rd0.rd_last, rd0.rd_data} !== 37'h0) begin
            failures++;
            $display("FAIL abort_release busy=%0b ok=%0b fail=%0b rv=%0b last=%0b data=%h expected all 0",
                     busy, auth_ok, auth_fail, rd0.rd_valid, rd0.rd_last, rd0.rd_data);
        end
        b = rv_cnt;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (rv_cnt - b !== 0 || auth_ok !== 1'b0) begin
            failures++;
            $display("FAIL abort_release_idle valid_cycles=%0d ok=%0b expected 0 0", rv_cnt - b, auth_ok);
        end
    endtask

    task automatic test_y0();
        int b;
        b        = ds1_cnt;
        exp_tag1 = TAG_Y0;
        tag_in1  = TAG_Y0;
        start1   = 1'b1;
        tick();
        start1   = 1'b0;
        checks++;
        if (dec_start1 !== 1'b1) begin
            failures++;
            $display("FAIL y0_launch dec_start=%0b expected 1", dec_start1);
        end
        tick();
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        checks++;
        if (dec_start1 !== 1'b0 || busy1 !== 1'b1) begin
            failures++;
            $display("FAIL y0_start_ignored dec_start=%0b busy=%0b expected 0 1", dec_start1, busy1);
        end
        dec_ready1 = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (auth_ok1 !== 1'b0 || busy1 !== 1'b1) begin
                failures++;
                $display("FAIL y0_compare%0d ok=%0b busy=%0b expected 0 1", i, auth_ok1, busy1);
            end
            tick();
        end
        checks++;
        if (auth_ok1 !== 1'b1 || auth_fail1 !== 1'b0 || busy1 !== 1'b0 || rd1.rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL y0_done ok=%0b fail=%0b busy=%0b rv=%0b expected 1 0 0 0",
                     auth_ok1, auth_fail1, busy1, rd1.rd_valid);
        end
        // dec_ready stays high in DONE; it must not restart anything.
        for (int i = 0; i < 3; i++) tick();
        dec_ready1 = 1'b0;
        checks++;
        if (auth_ok1 !== 1'b1 || busy1 !== 1'b0 || ds1_cnt - b !== 1 || rv1_cnt !== 0) begin
            failures++;
            $display("FAIL y0_hold ok=%0b busy=%0b dec_starts=%0d valid_cycles=%0d expected 1 0 1 0",
                     auth_ok1, busy1, ds1_cnt - b, rv1_cnt);
        end
    endtask

    task automatic test_reset_mid();
        rd0.rd_ready = 1'b0;
        do_op(TAG_A5, "rstmid");
        checks++;
        if (rd0.rd_valid !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_release rv=%0b expected 1", rd0.rd_valid);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({rd0.rd_valid, rd0.rd_data, rd0.rd_last, busy, auth_ok, auth_fail, dec_start} !== 38'h0) begin
            failures++;
            $display("FAIL rstmid_outputs rv=%0b data=%h last=%0b busy=%0b ok=%0b fail=%0b ds=%0b expected all 0",
                     rd0.rd_valid, rd0.rd_data, rd0.rd_last, busy, auth_ok, auth_fail, dec_start);
        end
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (busy !== 1'b0 || rd0.rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_after busy=%0b rv=%0b expected 0 0", busy, rd0.rd_valid);
        end
        rd0.rd_ready = 1'b1;
        do_op(TAG_A5, "rstmid_rerun");
        checks++;
        if (auth_ok !== 1'b1 || rd0.rd_data !== 32'h01234567) begin
            failures++;
            $display("FAIL rstmid_rerun_word0 ok=%0b data=%h expected 1 01234567", auth_ok, rd0.rd_data);
        end
        tick();
        checks++;
        if (rd0.rd_data !== 32'h89000000 || rd0.rd_last !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_rerun_word1 data=%h last=%0b expected 89000000 1", rd0.rd_data, rd0.rd_last);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || auth_ok !== 1'b1 || rd0.rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_rerun_done busy=%0b ok=%0b rv=%0b expected 0 1 0", busy, auth_ok, rd0.rd_valid);
        end
    endtask

    initial begin
        rd0.rd_ready = 1'b0;
        rd1.rd_ready = 1'b1;
        test_reset();
        test_match();
        test_mismatch();
        test_stall();
        test_abort_compare();
        test_abort_release();
        test_y0();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ascon_tag_verify.md
ASCON_TAG_VERIFY -- requirements
Module: ascon_tag_verify

Interface
REQ-001 SHALL have parameter y, default 40: plaintext length in bits; 0 is legal.
REQ-002 SHALL have parameter NW, default ceil(y/32): number of 32-bit output words; 0 when y=0.
REQ-003 SHALL have port clk  input  1: single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous and active-low (asserted at 0).
REQ-005 SHALL have port start  input  1: one-cycle request to begin an authenticated decryption.
REQ-006 SHALL have port abort  input  1: one-cycle request to cancel the current operation.
REQ-007 SHALL have port exp_tag  input  128: received (expected) tag; sampled on accepted start.
REQ-008 SHALL have port dec_start  output  1: one-cycle pulse driving the decryption core's start.
REQ-009 SHALL have port dec_ready  input  1: decryption core done flag; level, may stay high.
REQ-010 SHALL have port pt_in  input  y: decrypted plaintext from the core; valid while dec_ready=1.
REQ-011 SHALL have port tag_in  input  128: computed tag from the core; valid while dec_ready=1.
REQ-012 SHALL have port rd_valid  output  1: rd_data holds a released plaintext word.
REQ-013 SHALL have port rd_ready  input  1: consumer accepts word when rd_valid&rd_ready.
REQ-014 SHALL have port rd_data  output  32: plaintext word, MSB-first.
REQ-015 SHALL have port rd_last  output  1: current word is word NW-1.
REQ-016 SHALL have port auth_ok  output  1: tag match; plaintext released.
REQ-017 SHALL have port auth_fail  output  1: tag mismatch; plaintext discarded.
REQ-018 SHALL have port busy  output  1: state is not IDLE, DONE or FAIL.

Function
REQ-019 SHALL implement states IDLE, LAUNCH, WAIT_DEC, COMPARE, RELEASE, DONE, FAIL.
REQ-020 start in IDLE, DONE or FAIL SHALL latch exp_tag, clear auth_ok/auth_fail, and enter LAUNCH; start in any other state is ignored.
REQ-021 LAUNCH SHALL last exactly one cycle, assert dec_start=1 for that cycle only, then enter WAIT_DEC.
REQ-022 In WAIT_DEC, dec_ready=1 SHALL latch pt_in and tag_in, clear the diff accumulator and word index, and enter COMPARE.
REQ-023 dec_ready=1 while not in WAIT_DEC SHALL have no effect.
REQ-024 COMPARE SHALL take exactly 4 cycles regardless of data, OR-ing tag_w^exp_w into a 32-bit diff register each cycle, words taken from bit 127 downward.
REQ-025 After the 4th COMPARE cycle, diff==0 SHALL set auth_ok=1 and enter RELEASE (or DONE if y=0); diff!=0 SHALL set auth_fail=1, zero the plaintext and tag buffers, and enter FAIL.
REQ-026 Result SHALL be visible 5 cycles after the edge at which dec_ready was sampled.
REQ-027 In RELEASE, word k SHALL be pt[y-1-32k -: 32]; the final partial word is left-aligned and zero-padded (y=40: word0=pt[39:8], word1={pt[7:0],24'h0}).
REQ-028 rd_valid SHALL be 1 throughout RELEASE; rd_data/rd_last stable until handshake; index advances one word per handshake.
REQ-029 Handshake with rd_last=1 SHALL zero the plaintext buffer and enter DONE.
REQ-030 rd_valid, rd_data and rd_last SHALL be 0 outside RELEASE; plaintext never appears on rd_data in FAIL.
REQ-031 auth_ok and auth_fail SHALL never be 1 simultaneously; they hold in DONE/FAIL until the next accepted start, abort or reset.
REQ-032 abort in any state other than IDLE SHALL zero all buffers and flags and enter IDLE next cycle; abort has priority over start, dec_ready and rd handshake in the same cycle.
REQ-033 start and abort together in DONE/FAIL SHALL resolve to abort (IDLE).

Reset
REQ-034 rst=0 SHALL immediately force IDLE and clear every register; all outputs 0 while reset is asserted.
REQ-035 Reset deassertion SHALL be synchronised internally so the first state change occurs on or after the second rising edge after release.
REQ-036 Reset mid-operation SHALL discard latched plaintext/tag; no rd_valid until a new start.

Verification
REQ-037 y=40, exp_tag=tag_in=128'hA5..A5, pt_in=40'h0123456789, rd_ready=1 -> dec_start one pulse; auth_ok=1; words 32'h01234567, 32'h89000000; rd_last on word 2; DONE.
REQ-038 Same but tag_in differs only in bit 0 -> auth_fail=1 after exactly 4 COMPARE cycles; rd_valid never 1; FAIL.
REQ-039 rd_ready held 0 for 3 cycles in RELEASE -> rd_data=32'h01234567 held stable with rd_valid=1; no word skipped.
REQ-040 abort during COMPARE, and separately during RELEASE after word 0 -> IDLE next cycle, all outputs 0, no further words.
REQ-041 y=0, matching tags -> auth_ok=1, DONE directly, rd_valid never 1; start during WAIT_DEC ignored (no second dec_start).
REQ-042 rst=0 asserted mid-RELEASE -> outputs 0 same cycle; after release a new start runs a full clean sequence.
